neuron_mac_sequencer: RTL and testbench
=======================================

# neuron_mac_sequencer

Initiator side of the neuron multiplier handshake: accepts a stream of synaptic operand pairs, issues each pair to the pipelined multiplier with `start`/`mul_type`, waits for `mul_done`, and accumulates the returned 32-bit products into a membrane-potential sum. When the operand tagged `last` has been processed, it presents the sum, the term count and the error flags on a valid/ready output port. It sits between the synapse fetch logic and the multiplier, one instance per neuron core.

## Interface
- `TIMEOUT`, default 64: cycles allowed between `mul_start` and `mul_done` before a term is abandoned (≥ 2).
- `CNT_W`, default 16: width of the term counter.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous and active-low. Asserting it (0) clears all state immediately; release is synchronised by the integrator.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  sequencer accepts a pair this cycle.
- `in_a` / `in_b`  in  32 each  operands.
- `in_type`  in  2  00 unsigned×unsigned, 01 signed×signed, 10 signed×unsigned, 11 reserved.
- `in_last`  in  1  final term of the current neuron.
- `mul_start`  out  1  one-cycle request pulse to the multiplier.
- `mul_type`  out  2  registered copy of `in_type`.
- `mul_a` / `mul_b`  out  32 each  registered operands, held stable from issue through `mul_done`.
- `mul_ready`  in  1  multiplier idle and able to take `mul_start`.
- `mul_done`  in  1  one-cycle pulse; `mul_answer` is valid in the same cycle.
- `mul_answer`  in  32  low 32 bits of the product.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  32  two's-complement accumulated sum.
- `out_count`  out  CNT_W  number of terms added into `out_sum`.
- `out_ovf`  out  1  sticky signed-overflow flag for this neuron.
- `out_err`  out  1  sticky flag: at least one term timed out or used the reserved type.

## Operation
- States are S_IDLE, S_ISSUE, S_WAIT and S_OUT.
- **S_IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch a, b, type and last into the operand registers.
  - type ≠ 11: go to S_ISSUE.
  - type = 11: set err and skip the multiply. If last, go to S_OUT; otherwise stay in S_IDLE.
- **S_ISSUE**
  - If `mul_ready` = 1, drive `mul_start` = 1 for this cycle, clear the timer, and go to S_WAIT.
  - Otherwise keep `mul_start` = 0 and stay in S_ISSUE.
- **S_WAIT**
  - The timer increments every cycle.
  - On `mul_done`:
    - sum ← sum + `mul_answer`, wrapping modulo 2^32.
    - ovf ← ovf | signed overflow, i.e. the operand sign bits are equal and the result sign bit differs.
    - count ← count + 1, saturating at all-ones.
    - If last, go to S_OUT; otherwise go to S_IDLE.
  - Timeout: if the timer reaches TIMEOUT−1 and `mul_done` is still 0, set err, leave sum and count unchanged, and take the same last-based transition.
  - If `mul_done` arrives in the same cycle as the timeout, `mul_done` wins and no err is set.
- **S_OUT**
  - `out_valid` = 1, with `out_sum`/`out_count`/`out_ovf`/`out_err` held stable.
  - On `out_ready`, clear sum, count, ovf and err, then go to S_IDLE.
- `mul_done` outside S_WAIT is ignored (stale or late answers are discarded).
- `mul_start` is asserted only in S_ISSUE and never on two consecutive cycles.
- Reset forces S_IDLE and sets every register and output to 0, except `in_ready`, which is 1 because the block is in S_IDLE.
  - Reset mid-operation discards any partial sum.
  - The multiplier is reset by the same `rst`.

## Timing
- Accept a pair at edge 0 → S_ISSUE during cycle 1. With `mul_ready` = 1, `mul_start` is high during cycle 1 and the block is in S_WAIT from cycle 2.
- `mul_done` in cycle k:
  - the accumulated sum is visible at cycle k+1;
  - for a non-last term, `in_ready` = 1 at k+1;
  - for a last term, `out_valid` = 1 at k+1.
- Per-term occupancy = 2 + multiplier latency cycles; there is no overlap of terms.
- `mul_a`, `mul_b` and `mul_type` change only on an input handshake.
- `out_*` hold until `out_ready`; `in_ready` = 0 during S_OUT.
- Timeout is declared at cycle (issue + TIMEOUT); the next state is entered one cycle later.

## Test plan
- **Single term.** Type 00, a=7, b=6, last=1, 12-cycle multiplier model → `mul_start` one pulse; `out_sum`=42, `out_count`=1, `out_ovf`=0, `out_err`=0; `out_valid` one cycle after `mul_done`.
- **Signed sequence.** Terms (01: −3×5), (01: 4×4), (10: 0xFFFFFFFF×2, last) → `out_sum` = −15+16−2 = −1 = 0xFFFFFFFF, `out_count`=3.
- **Overflow.** Model returns 0x7FFFFFFF then 1 (last) → `out_sum`=0x80000000, `out_ovf`=1; the next neuron starts with ovf=0.
- **Timeout.** TIMEOUT=64; the model never pulses `mul_done` for term 1 of 2; term 2 returns 9 (last) → `out_err`=1, `out_sum`=9, `out_count`=1; a `mul_done` injected while in S_IDLE is ignored.
- **Back-pressure and ready stall.**
  - Hold `mul_ready`=0 for 5 cycles → `mul_start` stays 0, then pulses once.
  - Hold `out_ready`=0 for 10 cycles → outputs stable and `in_ready`=0 throughout.
- **Reserved type and reset.**
  - Type 11, last=1 → `out_err`=1, `out_count`=0, no `mul_start`.
  - Assert `rst`=0 mid-S_WAIT → all outputs 0 immediately, `in_ready`=1 after release, and the next neuron's sum is correct.

Source files
------------

// File: rtl/neuron_mac_sequencer_if.sv
// Signal bundle around the neuron MAC sequencer: operand stream in, multiplier request/answer, result out.
// Valid/ready: a transfer occurs on a rising edge with valid and ready both high; payload holds while valid waits.
interface neuron_mac_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [1:0]       in_type;
  logic             in_last;

  logic             mul_start;
  logic [1:0]       mul_type;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic             mul_ready;
  logic             mul_done;
  logic [31:0]      mul_answer;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_err;

  modport master (
    input  in_valid, in_a, in_b, in_type, in_last,
    output in_ready,
    output mul_start, mul_type, mul_a, mul_b,
    input  mul_ready, mul_done, mul_answer,
    output out_valid, out_sum, out_count, out_ovf, out_err,
    input  out_ready
  );

  modport slave (
    output in_valid, in_a, in_b, in_type, in_last,
    input  in_ready,
    input  mul_start, mul_type, mul_a, mul_b,
    output mul_ready, mul_done, mul_answer,
    input  out_valid, out_sum, out_count, out_ovf, out_err,
    output out_ready
  );
endinterface

// File: rtl/neuron_mac_sequencer.sv
// Issues one operand pair at a time to the pipelined multiplier and accumulates the products
// into a membrane-potential sum, presented with term count and sticky flags after the last term.
module neuron_mac_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  neuron_mac_sequencer_if.master bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam int            TW         = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t           state;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [1:0]       type_q;
  logic             last_q;
  logic [TW-1:0]    timer;
  logic [31:0]      sum;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             err;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [31:0]      sum_next;
  logic             ovf_term;

  assign sum_next = sum + bus.mul_answer;
  // Signed overflow: both addends share a sign and the wrapped result does not.
  assign ovf_term = (sum[31] == bus.mul_answer[31]) && (sum_next[31] != sum[31]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      type_q      <= '0;
      last_q      <= 1'b0;
      timer       <= '0;
      sum         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      err         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.in_a;
            b_q    <= bus.in_b;
            type_q <= bus.in_type;
            last_q <= bus.in_last;
            if (bus.in_type != 2'b11) begin
              state      <= S_ISSUE;
              in_ready_q <= 1'b0;
            end else begin
              err <= 1'b1;
              if (bus.in_last) begin
                state       <= S_OUT;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
              end
            end
          end
        end
        S_ISSUE: begin
          if (bus.mul_ready) begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          // A done pulse arriving on the timeout cycle still counts as a good term.
          if (bus.mul_done || (timer == TIMER_LAST)) begin
            if (bus.mul_done) begin
              sum <= sum_next;
              ovf <= ovf | ovf_term;
              if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
            end else begin
              err <= 1'b1;
            end
            if (last_q) begin
              state       <= S_OUT;
              out_valid_q <= 1'b1;
            end else begin
              state      <= S_IDLE;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            sum         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            err         <= 1'b0;
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mul_start = (state == S_ISSUE) && bus.mul_ready;
  assign bus.mul_type  = type_q;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum;
  assign bus.out_count = count;
  assign bus.out_ovf   = ovf;
  assign bus.out_err   = err;
  assign dbg_state     = state;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed and randomized neurons against an arithmetic reference of the accumulate rules,
// with a behavioural multiplier that answers after a configurable latency.
module tb_neuron_mac_sequencer;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  t;
    bit          drop;
    bit          ovr;
    logic [31:0] ov;
    int          lat;
  } term_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  neuron_mac_sequencer_if #(.CNT_W(CNT_W)) bus ();

  neuron_mac_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // multiplier configuration, written only by the main sequence
  bit          drop_mode = 1'b0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  int          lat = 4;
  int          inject_req = 0;

  // multiplier model state
  int          inject_ack = 0;
  int          start_count = 0;
  int          dbl_starts = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  bit          pending = 1'b0;
  bit          prev_start = 1'b0;
  int          countdown = 0;
  logic [31:0] ans = '0;

  term_t terms[$];

  function automatic logic [31:0] prod(logic [31:0] a, logic [31:0] b, logic [1:0] t);
    longint p;
    case (t)
      2'b01:   p = longint'($signed(a)) * longint'($signed(b));
      2'b10:   p = longint'($signed(a)) * longint'({32'b0, b});
      default: p = longint'({32'b0, a}) * longint'({32'b0, b});
    endcase
    return p[31:0];
  endfunction

  function automatic term_t mk(logic [31:0] a, logic [31:0] b, logic [1:0] t, int l);
    term_t r;
    r.a = a; r.b = b; r.t = t; r.drop = 1'b0; r.ovr = 1'b0; r.ov = '0; r.lat = l;
    return r;
  endfunction

  always @(negedge clk) begin
    bus.mul_done = 1'b0;
    if (!rst_n) begin
      pending        = 1'b0;
      prev_start     = 1'b0;
      bus.mul_answer = '0;
    end else begin
      if (pending) begin
        if (countdown == 0) begin
          bus.mul_done   = 1'b1;
          bus.mul_answer = ans;
          pending        = 1'b0;
          done_cyc       = cyc;
        end else begin
          countdown--;
        end
      end else if (inject_req != inject_ack) begin
        bus.mul_done   = 1'b1;
        bus.mul_answer = 32'h0000_1234;
        inject_ack     = inject_req;
      end
      if (bus.mul_start) begin
        if (prev_start) dbl_starts++;
        start_count++;
        start_cyc = cyc;
        pending   = !drop_mode;
        countdown = lat - 1;
        ans       = ovr_en ? ovr_val : prod(bus.mul_a, bus.mul_b, bus.mul_type);
      end
      prev_start = bus.mul_start;
    end
  end

  // scoreboard comparison
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: called at a falling edge, returns at the falling edge after the handshake
  task automatic send(term_t tm, bit last);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < TIMEOUT + 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    drop_mode   = tm.drop;
    ovr_en      = tm.ovr;
    ovr_val     = tm.ov;
    lat         = tm.lat;
    bus.in_valid = 1'b1;
    bus.in_a     = tm.a;
    bus.in_b     = tm.b;
    bus.in_type  = tm.t;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(string tag, int hold, logic [31:0] e_sum, int e_cnt,
                            bit e_ovf, bit e_err, bit chk_lat);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 4 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    if (chk_lat) check({tag, "_valid_latency"}, cyc, done_cyc + 1);
    check({tag, "_sum"}, bus.out_sum, e_sum);
    check({tag, "_count"}, bus.out_count, e_cnt);
    check({tag, "_ovf"}, bus.out_ovf, e_ovf);
    check({tag, "_err"}, bus.out_err, e_err);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
      check({tag, "_hold_sum"}, bus.out_sum, e_sum);
      check({tag, "_hold_count"}, bus.out_count, e_cnt);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drained"}, bus.out_valid, 0);
    check({tag, "_idle_ready"}, bus.in_ready, 1);
    check({tag, "_cleared"}, {bus.out_sum, 16'(bus.out_count), bus.out_ovf, bus.out_err}, 0);
  endtask

  // reference: sum, count and flags from the term list with plain arithmetic
  task automatic run_neuron(string tag, int hold);
    logic [31:0] e_sum;
    logic [31:0] p;
    longint      s;
    int          e_cnt;
    int          exp_starts;
    int          s0;
    bit          e_ovf;
    bit          e_err;
    term_t       lt;
    e_sum = '0; e_cnt = 0; exp_starts = 0; e_ovf = 1'b0; e_err = 1'b0;
    s0 = start_count;
    foreach (terms[i]) begin
      if (terms[i].t == 2'b11) begin
        e_err = 1'b1;
      end else begin
        exp_starts++;
        if (terms[i].drop) begin
          e_err = 1'b1;
        end else begin
          p = terms[i].ovr ? terms[i].ov : prod(terms[i].a, terms[i].b, terms[i].t);
          s = longint'($signed(e_sum)) + longint'($signed(p));
          if (s > 64'sd2147483647 || s < -64'sd2147483648) e_ovf = 1'b1;
          e_sum = e_sum + p;
          e_cnt++;
        end
      end
      send(terms[i], i == terms.size() - 1);
    end
    lt = terms[terms.size() - 1];
    get_result(tag, hold, e_sum, e_cnt, e_ovf, e_err, (lt.t != 2'b11) && !lt.drop);
    check({tag, "_starts"}, start_count - s0, exp_starts);
    terms.delete();
  endtask

  initial begin
    term_t      t;
    int         n;
    int         s0;
    int         len;
    logic [1:0] st;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_type   = '0;
    bus.in_last   = 1'b0;
    bus.mul_ready = 1'b1;
    bus.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mul_start", bus.mul_start, 0);
    check("rst_outputs", {bus.out_sum, 16'(bus.out_count), bus.out_ovf, bus.out_err}, 0);
    check("rst_mul_regs", {bus.mul_a, bus.mul_b, bus.mul_type}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single term, 12-cycle multiplier
    terms.push_back(mk(32'd7, 32'd6, 2'b00, 12));
    run_neuron("single", 0);

    // signed sequence
    terms.push_back(mk(32'hFFFF_FFFD, 32'd5, 2'b01, 3));
    terms.push_back(mk(32'd4, 32'd4, 2'b01, 2));
    terms.push_back(mk(32'hFFFF_FFFF, 32'd2, 2'b10, 5));
    run_neuron("signed", 0);

    // overflow, then a fresh neuron starts with ovf clear
    t = mk(32'd1, 32'd1, 2'b00, 4); t.ovr = 1'b1; t.ov = 32'h7FFF_FFFF;
    terms.push_back(t);
    t = mk(32'd1, 32'd1, 2'b00, 4); t.ovr = 1'b1; t.ov = 32'd1;
    terms.push_back(t);
    run_neuron("overflow", 0);
    terms.push_back(mk(32'd2, 32'd3, 2'b00, 3));
    run_neuron("after_ovf", 0);

    // timeout on term 1, stale done in idle, term 2 returns 9
    s0 = start_count;
    t = mk(32'd3, 32'd3, 2'b00, 4); t.drop = 1'b1;
    send(t, 1'b0);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < TIMEOUT + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_ready_cycle", cyc, start_cyc + TIMEOUT + 1);
    check("timeout_sum_kept", bus.out_sum, 0);
    inject_req++;
    repeat (3) @(negedge clk);
    check("stale_done_sum", bus.out_sum, 0);
    check("stale_done_count", bus.out_count, 0);
    check("stale_done_idle", bus.in_ready, 1);
    t = mk(32'd1, 32'd1, 2'b00, 5); t.ovr = 1'b1; t.ov = 32'd9;
    send(t, 1'b1);
    get_result("timeout", 0, 32'd9, 1, 1'b0, 1'b1, 1'b1);
    check("timeout_starts", start_count - s0, 2);

    // multiplier not ready for 5 cycles, consumer stalls 10 cycles
    s0 = start_count;
    bus.mul_ready = 1'b0;
    send(mk(32'd11, 32'd13, 2'b00, 6), 1'b1);
    st = dbg_state;
    for (int i = 0; i < 5; i++) begin
      check("stall_no_start", bus.mul_start, 0);
      check("stall_state", dbg_state, st);
      @(negedge clk);
    end
    check("stall_start_count", start_count - s0, 0);
    @(posedge clk);
    #1 bus.mul_ready = 1'b1;
    @(negedge clk);
    get_result("stall", 10, 32'd143, 1, 1'b0, 1'b0, 1'b1);
    check("stall_starts", start_count - s0, 1);

    // reserved type as the last term
    terms.push_back(mk(32'd5, 32'd5, 2'b11, 1));
    run_neuron("reserved", 0);

    // reset in the middle of a wait discards the partial sum
    send(mk(32'd100, 32'd3, 2'b00, 2), 1'b0);
    send(mk(32'd7, 32'd7, 2'b00, 30), 1'b1);
    repeat (6) @(negedge clk);
    check("pre_reset_sum", bus.out_sum, 300);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {bus.out_sum, 16'(bus.out_count), bus.out_ovf, bus.out_err}, 0);
    check("mid_rst_valid_start", {bus.out_valid, bus.mul_start}, 0);
    check("mid_rst_mul_regs", {bus.mul_a, bus.mul_b, bus.mul_type}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    terms.push_back(mk(32'hFFFF_FFF0, 32'd3, 2'b01, 3));
    terms.push_back(mk(32'd9, 32'd9, 2'b00, 2));
    run_neuron("post_reset", 0);

    // randomized neurons
    for (int nn = 0; nn < 10; nn++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        t = mk($urandom, $urandom, 2'($urandom_range(0, 2)), $urandom_range(1, 8));
        if ($urandom_range(0, 9) == 0) t.t = 2'b11;
        if ($urandom_range(0, 1) == 1) begin
          t.ovr = 1'b1;
          t.ov  = $urandom;
        end
        terms.push_back(t);
      end
      run_neuron("rand", $urandom_range(0, 3));
    end

    check("no_back_to_back_start", dbl_starts, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
